mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_n_if.sv | 36 +++
 rtl/mux_arb_n.sv | 103 ++++++++++
 tb/tb_mux_arb_n.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_n_if.sv
// Bundle of the N-channel input side and the single registered output side of mux_arb_n.
// The master drives the channel data/valid and out_ready; the slave is the arbiter itself.
interface mux_arb_n_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SelW-1:0]    out_sel;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_sel
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_sel
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
// MODE 0 is fixed priority (lowest index wins), MODE 1 is round-robin from a rotating pointer.
module mux_arb_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    mux_arb_n_if.slave  bus
);
    localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

    logic [SelW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SelW-1:0]  sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             load_en;
    logic [SelW-1:0]  start;
    logic [SelW-1:0]  cand;
    logic [SelW-1:0]  gidx;
    logic             gany;
    logic [N-1:0]     grant;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] gdata;
    logic             xfer;

    // (base + off) mod N, valid because both operands are already below N.
    function automatic logic [SelW-1:0] wrap_add(input logic [SelW-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return SelW'(s);
    endfunction

    assign start = (MODE == 1) ? ptr_q : '0;

    always_comb begin
        cand  = '0;
        gidx  = '0;
        gany  = 1'b0;
        grant = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = wrap_add(start, k);
            if (!gany && bus.in_valid[cand]) begin
                gany = 1'b1;
                gidx = cand;
            end
        end
        if (gany) begin
            grant[gidx] = 1'b1;
        end
    end

    assign load_en = !valid_q || bus.out_ready;
    // Reset gates the handshake so nothing is accepted during the reset cycle.
    assign ready   = (reset_n && load_en) ? grant : '0;
    assign xfer    = |ready;
    assign gdata   = bus.in_data[32'(gidx)*WIDTH +: WIDTH];

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = gdata;
            sel_d   = gidx;
            if (MODE == 1) begin
                ptr_d = wrap_add(gidx, 1);
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

    a_ready_onehot: assert property (@(posedge clock) $onehot0(bus.in_ready));
    a_ready_valid:  assert property (@(posedge clock) (bus.in_ready & ~bus.in_valid) == '0);
endmodule

// File: tb/tb_mux_arb_n.sv
// Drives a fixed-priority and a round-robin mux_arb_n with identical stimulus and
// checks both against a behavioural model with a per-instance expected-word queue.
module tb_mux_arb_n;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   vld;
    logic [N*W-1:0] dat;
    logic           ordy;

    mux_arb_n_if #(.WIDTH(W), .N(N)) bus0 ();
    mux_arb_n_if #(.WIDTH(W), .N(N)) bus1 ();

    assign bus0.in_data   = dat;
    assign bus0.in_valid  = vld;
    assign bus0.out_ready = ordy;
    assign bus1.in_data   = dat;
    assign bus1.in_valid  = vld;
    assign bus1.out_ready = ordy;

    mux_arb_n #(.WIDTH(W), .N(N), .MODE(0)) dut0 (.clock(clk), .reset_n(rst_n), .bus(bus0));
    mux_arb_n #(.WIDTH(W), .N(N), .MODE(1)) dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1));

    logic [N-1:0]  o_rdy   [2];
    logic [W-1:0]  o_data  [2];
    logic          o_valid [2];
    logic [SW-1:0] o_sel   [2];
    assign o_rdy[0]   = bus0.in_ready;
    assign o_rdy[1]   = bus1.in_ready;
    assign o_data[0]  = bus0.out_data;
    assign o_data[1]  = bus1.out_data;
    assign o_valid[0] = bus0.out_valid;
    assign o_valid[1] = bus1.out_valid;
    assign o_sel[0]   = bus0.out_sel;
    assign o_sel[1]   = bus1.out_sel;

    int            checks = 0;
    int            errors = 0;
    int            m_ptr   [2];
    bit            m_valid [2];
    logic [W-1:0]  m_data  [2];
    logic [SW-1:0] m_sel   [2];
    bit            pend    [2];
    int            pg      [2];
    word_t         sb0[$];
    word_t         sb1[$];
    logic [W-1:0]  held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input int mode, input int ptr, input logic [N-1:0] v);
        int start;
        int idx;
        start = (mode == 1) ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check in_ready before the edge, then outputs and pointer after it.
    task automatic cycle();
        int           g;
        bit           load;
        logic [N-1:0] er;
        word_t        w;
        #1;
        for (int m = 0; m < 2; m++) begin
            load    = !m_valid[m] || ordy;
            g       = model_grant(m, m_ptr[m], vld);
            er      = '0;
            pend[m] = 1'b0;
            if (rst_n && load && g >= 0) begin
                er[g]   = 1'b1;
                pend[m] = 1'b1;
                pg[m]   = g;
                w.d     = dat[g*W +: W];
                w.s     = SW'(g);
                if (m == 0) sb0.push_back(w);
                else        sb1.push_back(w);
            end
            chk($sformatf("m%0d in_ready", m), 64'(o_rdy[m]), 64'(er));
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_valid[m] = 1'b0;
                m_data[m]  = '0;
                m_sel[m]   = '0;
                m_ptr[m]   = 0;
            end else if (pend[m]) begin
                if (m == 0) w = sb0.pop_front();
                else        w = sb1.pop_front();
                m_valid[m] = 1'b1;
                m_data[m]  = w.d;
                m_sel[m]   = w.s;
                if (m == 1) m_ptr[m] = (pg[m] + 1) % N;
            end else if (ordy) begin
                m_valid[m] = 1'b0;
            end
            chk($sformatf("m%0d out_valid", m), 64'(o_valid[m]), 64'(m_valid[m]));
            chk($sformatf("m%0d out_data", m), 64'(o_data[m]), 64'(m_data[m]));
            chk($sformatf("m%0d out_sel", m), 64'(o_sel[m]), 64'(m_sel[m]));
        end
        chk("m0 ptr", 64'(dut0.ptr_q), 64'(m_ptr[0]));
        chk("m1 ptr", 64'(dut1.ptr_q), 64'(m_ptr[1]));
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) dat[i*W +: W] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        dat   = '0;
        ordy  = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]   = 0;
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = '0;
        end
        @(negedge clk);
        cycle();

        // Reset with every channel offering: nothing may be accepted.
        vld = 4'hf;
        rand_data();
        cycle();

        rst_n = 1'b1;
        vld   = 4'b1010;
        dat   = {32'h33333333, 32'h0, 32'h11111111, 32'h0};
        cycle();
        chk("basic data", 64'(o_data[0]), 64'h11111111);
        chk("basic sel", 64'(o_sel[0]), 64'd1);

        vld = '0;
        cycle();
        chk("idle valid falls", 64'(o_valid[0]), 64'd0);
        chk("idle data holds", 64'(o_data[0]), 64'h11111111);
        cycle();

        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        vld   = 4'hf;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cycle();
            chk("rr sequence", 64'(o_sel[1]), 64'(k % N));
            chk("rr no bubble", 64'(o_valid[1]), 64'd1);
        end

        // Backpressure: output held, no acceptance, then release.
        ordy = 1'b0;
        vld  = 4'b0001;
        held = o_data[1];
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cycle();
            chk("bp hold", 64'(o_data[1]), 64'(held));
        end
        ordy = 1'b1;
        cycle();
        chk("bp release sel", 64'(o_sel[1]), 64'd0);
        vld = '0;
        cycle();

        vld = 4'b0100;
        cycle();
        chk("ptr after ch2", 64'(dut1.ptr_q), 64'd3);
        vld = 4'b0001;
        cycle();
        chk("wrap ptr", 64'(dut1.ptr_q), 64'd1);
        vld = 4'b0010;
        cycle();
        vld = '0;
        cycle();

        ordy         = 1'b0;
        vld          = 4'b0001;
        dat[W-1:0]   = 32'hDEADBEEF;
        cycle();
        cycle();
        chk("held word", 64'(o_data[1]), 64'hDEADBEEF);
        rst_n = 1'b0;
        cycle();
        chk("reset drops word", 64'(o_valid[1]), 64'd0);
        rst_n = 1'b1;
        vld   = 4'hf;
        ordy  = 1'b1;
        cycle();
        chk("first grant after reset", 64'(o_sel[1]), 64'd0);

        for (int k = 0; k < 80; k++) begin
            vld  = N'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            rand_data();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
